pc_fetch_ctrl: RTL

Sequencing controller for the OTTER 5-stage pipeline's program-counter register. It drives the PC's write enable, reset and next-address input. Each cycle it chooses among sequential fetch, EX-stage redirects (branch/jump, MRET), hazard stalls, a post-reset hold, and interrupt entry with a pipeline drain. It also generates the IF/ID and ID/EX flush strobes and the captured exception PC for the CSR file.

---
 rtl/pc_fetch_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: OTTER pipeline PC sequencing controller with redirects, stalls,
// post-reset hold and interrupt entry through a pipeline drain.
module pc_fetch_ctrl #(
    parameter int unsigned RST_CYCLES   = 2,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] pc_count_i,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        mret_i,
    input  logic [31:0] mepc_i,
    input  logic        intr_i,
    input  logic        mie_i,
    input  logic [31:0] mtvec_i,
    output logic        pc_rst_o,
    output logic        pc_write_o,
    output logic [31:0] pc_din_o,
    output logic        flush_ifid_o,
    output logic        flush_idex_o,
    output logic        intr_taken_o,
    output logic [31:0] intr_epc_o
);
    typedef enum logic [1:0] {RST_HOLD, RUN, DRAIN, VECTOR} state_t;

    localparam logic [3:0] RST_INIT   = 4'(RST_CYCLES);
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] seq_pc;
    logic        redirect;
    logic        take_intr;

    assign seq_pc    = pc_count_i + 32'd4;
    assign redirect  = mret_i | br_taken_i;
    // a redirect wins; the interrupt is re-evaluated against the new target next cycle
    assign take_intr = intr_i & mie_i & ~redirect;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RST_HOLD;
            cnt_q   <= RST_INIT;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        epc_d   = epc_q;
        case (state_q)
            RST_HOLD: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = RUN;
            end
            RUN: begin
                if (take_intr) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_INIT;
                    epc_d   = pc_count_i;
                end
            end
            DRAIN: begin
                // redirects in flight retarget the saved return address and stall the drain count
                if (mret_i) epc_d = mepc_i;
                else if (br_taken_i) epc_d = br_target_i;
                else if (!stall_i) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_d = VECTOR;
                end
            end
            VECTOR:  state_d = RUN;
            default: state_d = RST_HOLD;
        endcase
    end

    always_comb begin
        pc_rst_o     = 1'b0;
        pc_write_o   = 1'b0;
        pc_din_o     = seq_pc;
        flush_ifid_o = 1'b0;
        flush_idex_o = 1'b0;
        intr_taken_o = 1'b0;
        intr_epc_o   = '0;
        case (state_q)
            RST_HOLD: begin
                pc_rst_o     = 1'b1;
                flush_ifid_o = 1'b1;
                flush_idex_o = 1'b1;
            end
            RUN: begin
                pc_din_o     = mret_i ? mepc_i : br_taken_i ? br_target_i : seq_pc;
                pc_write_o   = redirect | (~(intr_i & mie_i) & ~stall_i);
                flush_ifid_o = redirect | (intr_i & mie_i);
                flush_idex_o = redirect;
            end
            DRAIN: begin
                flush_ifid_o = 1'b1;
                flush_idex_o = redirect;
            end
            VECTOR: begin
                pc_write_o   = 1'b1;
                pc_din_o     = mtvec_i;
                flush_ifid_o = 1'b1;
                flush_idex_o = 1'b1;
                intr_taken_o = 1'b1;
                intr_epc_o   = epc_q;
            end
            default: pc_rst_o = 1'b1;
        endcase
        if (!rst_n_i) pc_din_o = '0;
    end
endmodule
